blk64_fetch_ctrl: RTL

//   Sequencer that fetches consecutive 8x8 blocks of DW-bit words from SRAM into 64-entry local

---
 rtl/blk64_fetch_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/blk64_fetch_ctrl.sv
// Block fetch sequencer: streams 64-word blocks from SRAM into one or two local block buffers.
// Optional feature macro: BLK64_PINGPONG_EN (two buffers, fetch of the next block overlaps consumption).
module blk64_fetch_ctrl #(
    parameter int AW       = 18,
    parameter int DW       = 16,
    parameter int SRAM_LAT = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [7:0]    num_blocks,
    output logic          sram_rd,
    output logic [AW-1:0] sram_addr,
    input  logic [DW-1:0] sram_rdata,
    output logic          buf_we,
    output logic          buf_sel,
    output logic [5:0]    buf_waddr,
    output logic [DW-1:0] buf_wdata,
    output logic          blk_valid,
    output logic          blk_rsel,
    input  logic          blk_ready,
    output logic          busy,
    output logic          done
);

`ifdef BLK64_PINGPONG_EN
    localparam logic PP = 1'b1;
`else
    localparam logic PP = 1'b0;
`endif

    localparam logic [2:0] LAT_M1 = 3'(SRAM_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_DRAIN    = 3'd2,
        S_WAIT_BUF = 3'd3,
        S_FLUSH    = 3'd4
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [AW-1:0] addr_r;
    logic [7:0]    nblk_r, blk_r;
    logic [5:0]    k_r;
    logic [2:0]    drain_cnt_r;
    logic [1:0]    full_r, full_clr_s, clr_s, set_s;
    logic          wr_sel_r, rd_sel_r, done_r;
    logic          accept_s, drain_end_s, last_blk_s, fetch_s;
    logic          start_go_s, zero_done_s, flush_done_s;
    logic          pipe_v_r   [SRAM_LAT];
    logic          pipe_sel_r [SRAM_LAT];
    logic [5:0]    pipe_k_r   [SRAM_LAT];

    // Buffer occupancy: a set from the fill side and a clear from the consumer may land together.
    always_comb begin
        fetch_s     = (state_r == S_FETCH);
        accept_s    = full_r[rd_sel_r] & blk_ready;
        drain_end_s = (state_r == S_DRAIN) && (drain_cnt_r == LAT_M1);
        last_blk_s  = (({1'b0, blk_r} + 9'd1) == {1'b0, nblk_r});
        clr_s       = accept_s ? (2'b01 << rd_sel_r) : 2'b00;
        set_s       = drain_end_s ? (2'b01 << wr_sel_r) : 2'b00;
        full_clr_s  = full_r & ~clr_s;
    end

    // Next-state decode; buffer checks see this cycle's acceptance so a freed buffer is reused at once.
    always_comb begin
        state_nxt_s  = state_r;
        start_go_s   = 1'b0;
        zero_done_s  = 1'b0;
        flush_done_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    if (num_blocks != 8'd0) begin
                        state_nxt_s = S_FETCH;
                        start_go_s  = 1'b1;
                    end else begin
                        zero_done_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_FETCH: begin
                if (k_r == 6'd63) begin
                    state_nxt_s = S_DRAIN;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (drain_end_s) begin
                    if (last_blk_s) begin
                        state_nxt_s = S_FLUSH;
                    end else if (!PP || full_clr_s[~wr_sel_r]) begin
                        state_nxt_s = S_WAIT_BUF;
                    end else begin
                        state_nxt_s = S_FETCH;
                    end
                end else begin
                    state_nxt_s = S_DRAIN;
                end
            end
            S_WAIT_BUF: begin
                if (!full_clr_s[wr_sel_r]) begin
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_WAIT_BUF;
                end
            end
            S_FLUSH: begin
                if (full_clr_s == 2'b00) begin
                    state_nxt_s  = S_IDLE;
                    flush_done_s = 1'b1;
                end else begin
                    state_nxt_s = S_FLUSH;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_r <= S_IDLE;
        else       state_r <= state_nxt_s;
    end

    // Address, block/word counters and drain timer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_r      <= {AW{1'b0}};
            nblk_r      <= 8'd0;
            blk_r       <= 8'd0;
            k_r         <= 6'd0;
            drain_cnt_r <= 3'd0;
            wr_sel_r    <= 1'b0;
        end else begin
            if (start_go_s) begin
                addr_r <= base_addr;
                nblk_r <= num_blocks;
                blk_r  <= 8'd0;
                k_r    <= 6'd0;
            end else if (fetch_s) begin
                addr_r <= addr_r + {{(AW-1){1'b0}}, 1'b1};
                k_r    <= k_r + 6'd1;
            end
            if (drain_end_s) begin
                drain_cnt_r <= 3'd0;
                wr_sel_r    <= PP ? ~wr_sel_r : 1'b0;
                blk_r       <= blk_r + 8'd1;
            end else if (state_r == S_DRAIN) begin
                drain_cnt_r <= drain_cnt_r + 3'd1;
            end else begin
                drain_cnt_r <= 3'd0;
            end
        end
    end

    // Producer/consumer handshake state and done pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full_r   <= 2'b00;
            rd_sel_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            full_r <= full_clr_s | set_s;
            done_r <= zero_done_s | flush_done_s;
            if (accept_s) rd_sel_r <= PP ? ~rd_sel_r : 1'b0;
        end
    end

    // Write-side delay line matching the SRAM read latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SRAM_LAT; i++) begin
                pipe_v_r[i]   <= 1'b0;
                pipe_sel_r[i] <= 1'b0;
                pipe_k_r[i]   <= 6'd0;
            end
        end else begin
            pipe_v_r[0]   <= fetch_s;
            pipe_sel_r[0] <= wr_sel_r;
            pipe_k_r[0]   <= k_r;
            for (int i = 1; i < SRAM_LAT; i++) begin
                pipe_v_r[i]   <= pipe_v_r[i-1];
                pipe_sel_r[i] <= pipe_sel_r[i-1];
                pipe_k_r[i]   <= pipe_k_r[i-1];
            end
        end
    end

    assign sram_rd   = fetch_s;
    assign sram_addr = addr_r;
    assign buf_we    = pipe_v_r[SRAM_LAT-1];
    assign buf_sel   = pipe_sel_r[SRAM_LAT-1];
    assign buf_waddr = pipe_k_r[SRAM_LAT-1];
    assign buf_wdata = buf_we ? sram_rdata : {DW{1'b0}};
    assign blk_valid = full_r[rd_sel_r];
    assign blk_rsel  = rd_sel_r;
    assign busy      = (state_r != S_IDLE);
    assign done      = done_r;

endmodule
